// File: rtl/mmio_timer_pkg.sv
`default_nettype none
// ============================================================================
//  mmio_timer_pkg
//  Shared register map, CTRL layout and byte-lane merge helper.
//  Revision: 1.0
// ============================================================================
package mmio_timer_pkg;

    localparam int ADDR_W = 14;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 14'd0;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE = 14'd1;
    localparam logic [ADDR_W-1:0] ADDR_COUNT    = 14'd2;
    localparam logic [ADDR_W-1:0] ADDR_COMPARE  = 14'd3;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 14'd4;
    localparam logic [ADDR_W-1:0] ADDR_MCNT     = 14'd5;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    localparam logic [3:0] WEB_READ = 4'hF;

    // Field order puts en at bit 0, matching the CTRL word layout
    typedef struct packed {
        logic irq_en;
        logic auto_reload;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_word,
        input logic [31:0] din,
        input logic [3:0]  web
    );
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (!web[i]) begin
                res[8*i +: 8] = din[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_timer_if.sv
`default_nettype none
// ============================================================================
//  mmio_timer_if
//  SRAM-style port bundle (CS/OE/WEB/A/DI/DO) between CPU and timer.
//  Revision: 1.0
// ============================================================================
interface mmio_timer_if;
    import mmio_timer_pkg::*;

    logic              CS;
    logic              OE;
    logic [3:0]        WEB;
    logic [ADDR_W-1:0] A;
    logic [31:0]       DI;
    logic [31:0]       DO;

    modport master (output CS, OE, WEB, A, DI, input DO);
    modport slave  (input CS, OE, WEB, A, DI, output DO);
endinterface
`default_nettype wire

// File: rtl/mmio_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  timer_prescaler
//  Divides clk by (div+1) while enabled; tick marks the wrap cycle.
//  Revision: 1.0
// ============================================================================
module timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] r_pcnt;
    logic                  w_wrap;

    assign w_wrap = (r_pcnt == div);
    // tick depends only on current state so a same-cycle clr/disable does not suppress it
    assign tick   = en & w_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcnt <= '0;
        end else if (clr || !en || w_wrap) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_timer.sv
`default_nettype none
// ============================================================================
//  mmio_timer
//  Prescaled 32-bit timer with compare, match counter and irq on an SRAM port.
//  Revision: 1.0
// ============================================================================
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int MCNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    mmio_timer_if.slave   bus,
    output logic          irq
);

    ctrl_t                 r_ctrl;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_count;
    logic [31:0]           r_compare;
    logic                  r_match;
    logic [MCNT_W-1:0]     r_mcnt;
    logic [31:0]           r_rdata;
    logic                  r_irq;

    logic        w_rd;
    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_prescale;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic [31:0] w_rmux;
    logic [31:0] w_merged;
    logic        w_tick;
    logic        w_tick_eff;
    logic        w_match_set;
    logic        w_match_clr;
    logic        w_match_next;
    ctrl_t       w_ctrl_next;

    assign w_rd          = bus.CS && (bus.WEB == WEB_READ);
    assign w_wr          = bus.CS && (bus.WEB != WEB_READ);
    assign w_wr_ctrl     = w_wr && (bus.A == ADDR_CTRL);
    assign w_wr_prescale = w_wr && (bus.A == ADDR_PRESCALE);
    assign w_wr_count    = w_wr && (bus.A == ADDR_COUNT);
    assign w_wr_compare  = w_wr && (bus.A == ADDR_COMPARE);
    assign w_wr_status   = w_wr && (bus.A == ADDR_STATUS);

    always_comb begin
        w_rmux = 32'h0;
        case (bus.A)
            ADDR_CTRL:     w_rmux[2:0]            = r_ctrl;
            ADDR_PRESCALE: w_rmux[PRESCALE_W-1:0] = r_prescale;
            ADDR_COUNT:    w_rmux                 = r_count;
            ADDR_COMPARE:  w_rmux                 = r_compare;
            ADDR_STATUS:   w_rmux[0]              = r_match;
            ADDR_MCNT:     w_rmux[MCNT_W-1:0]     = r_mcnt;
            default:       w_rmux                 = 32'h0;
        endcase
    end

    // Disabled lanes keep the current register contents seen through the read mux
    assign w_merged = byte_merge(w_rmux, bus.DI, bus.WEB);

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (r_ctrl.en),
        .clr  (w_wr_prescale | w_wr_count),
        .div  (r_prescale),
        .tick (w_tick)
    );

    // A CPU write to COUNT overrides any tick landing on the same edge
    assign w_tick_eff   = w_tick & ~w_wr_count;
    assign w_match_set  = w_tick_eff & (r_count == r_compare);
    assign w_match_clr  = w_wr_status & ~bus.WEB[0] & bus.DI[0];
    assign w_match_next = w_match_set | (r_match & ~w_match_clr);

    always_comb begin
        w_ctrl_next = r_ctrl;
        if (w_wr_ctrl) begin
            w_ctrl_next.en          = w_merged[CTRL_EN];
            w_ctrl_next.auto_reload = w_merged[CTRL_AR];
            w_ctrl_next.irq_en      = w_merged[CTRL_IE];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_count    <= '0;
            r_compare  <= '0;
            r_match    <= 1'b0;
            r_mcnt     <= '0;
            r_rdata    <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_ctrl  <= w_ctrl_next;
            r_match <= w_match_next;
            r_irq   <= w_match_next & w_ctrl_next.irq_en;

            if (w_wr_prescale) begin
                r_prescale <= w_merged[PRESCALE_W-1:0];
            end
            if (w_wr_compare) begin
                r_compare <= w_merged;
            end

            if (w_wr_count) begin
                r_count <= w_merged;
            end else if (w_match_set && r_ctrl.auto_reload) begin
                r_count <= 32'h0;
            end else if (w_tick_eff) begin
                r_count <= r_count + 32'd1;
            end

            if (w_match_set && (r_mcnt != {MCNT_W{1'b1}})) begin
                r_mcnt <= r_mcnt + {{(MCNT_W-1){1'b0}}, 1'b1};
            end

            if (w_rd) begin
                r_rdata <= w_rmux;
            end
        end
    end

    assign bus.DO = bus.OE ? r_rdata : 32'h0;
    assign irq    = r_irq;

endmodule
`default_nettype wire
